// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage between EX/MEM and MEM/WB.
// Issues loads/stores to a variable-latency data memory over a registered
// req/ack handshake, stalls upstream while an access is in flight, and hands
// load data plus writeback control to the MEM/WB register.
// Optional feature: define MEM_TIMEOUT_EN to add an access watchdog that
// abandons an unacknowledged request after TIMEOUT_CYCLES REQ cycles and
// pulses mem_err.
module mem_access_stage #(
    parameter int DATAPATH_WIDTH     = 64,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int MEM_ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATAPATH_WIDTH-1:0]     accum_in,
    input  logic [DATAPATH_WIDTH-1:0]     store_data_in,
    input  logic                          mem_rd_in,
    input  logic                          mem_wr_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
    input  logic                          WR_en_in,
    input  logic                          mem_reg_sel_in,
    output logic                          stall_out,
    output logic                          dmem_req,
    output logic                          dmem_we,
    output logic [MEM_ADDR_WIDTH-1:0]     dmem_addr,
    output logic [DATAPATH_WIDTH-1:0]     dmem_wdata,
    input  logic                          dmem_ack,
    input  logic [DATAPATH_WIDTH-1:0]     dmem_rdata,
    output logic [DATAPATH_WIDTH-1:0]     mem_data_out,
    output logic [DATAPATH_WIDTH-1:0]     accum_out,
    output logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out,
    output logic                          WR_en_out,
    output logic                          mem_reg_sel_out,
    output logic                          mem_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                state;
    logic [DATAPATH_WIDTH-1:0] rdata_q;
    logic                      memop;
    logic                      timeout_hit;
    logic                      err_q;

    assign memop = in_valid & (mem_rd_in | mem_wr_in);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;

    // Fires on the last permitted REQ cycle; an ack in that same cycle wins.
    assign timeout_hit = (state == REQ) && !dmem_ack &&
                         (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared while idle (so it starts at zero on REQ entry),
    // counts REQ cycles; err_q marks the DONE cycle that follows a timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (state == REQ)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
        end
    end
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign err_q       = 1'b0;
`endif

    assign mem_err = err_q;

    // Access FSM plus the registered memory-request outputs and load capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_wr_in;
                        dmem_addr  <= accum_in[MEM_ADDR_WIDTH-1:0];
                        dmem_wdata <= store_data_in;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        // dmem_we is the registered op type: only loads capture.
                        if (!dmem_we)
                            rdata_q <= dmem_rdata;
                        state <= DONE;
                    end else if (timeout_hit) begin
                        dmem_req <= 1'b0;
                        rdata_q  <= '1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall and gated writeback enable; both forced low while reset is held.
    always_comb begin
        stall_out = 1'b0;
        WR_en_out = 1'b0;
        case (state)
            IDLE: begin
                stall_out = memop;
                WR_en_out = in_valid & ~memop & WR_en_in;
            end
            REQ: begin
                stall_out = 1'b1;
            end
            DONE: begin
                WR_en_out = WR_en_in & ~err_q;
            end
            default: begin
                stall_out = 1'b0;
                WR_en_out = 1'b0;
            end
        endcase
        if (!reset) begin
            stall_out = 1'b0;
            WR_en_out = 1'b0;
        end
    end

    assign mem_data_out    = rdata_q;
    assign accum_out       = accum_in;
    assign WR_addr_out     = WR_addr_in;
    assign mem_reg_sel_out = mem_reg_sel_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed cases plus randomized instruction
// stream, checked against a transaction-level model of the stage.
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] accum_in;
    logic [63:0] store_data_in;
    logic        mem_rd_in;
    logic        mem_wr_in;
    logic [4:0]  WR_addr_in;
    logic        WR_en_in;
    logic        mem_reg_sel_in;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [9:0]  dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic [63:0] mem_data_out;
    logic [63:0] accum_out;
    logic [4:0]  WR_addr_out;
    logic        WR_en_out;
    logic        mem_reg_sel_out;
    logic        mem_err;

    int          n_chk;
    int          n_pass;
    logic [63:0] model_rdata;

    mem_access_stage #(
        .DATAPATH_WIDTH(64),
        .REGFILE_ADDR_WIDTH(5),
        .MEM_ADDR_WIDTH(10),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .accum_in(accum_in),
        .store_data_in(store_data_in), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
        .WR_addr_in(WR_addr_in), .WR_en_in(WR_en_in), .mem_reg_sel_in(mem_reg_sel_in),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .mem_data_out(mem_data_out), .accum_out(accum_out),
        .WR_addr_out(WR_addr_out), .WR_en_out(WR_en_out),
        .mem_reg_sel_out(mem_reg_sel_out), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One instruction held at the stage until it retires. Entered and left
    // 1 time unit after a rising edge. k = cycles from req rise to ack.
    task automatic do_instr(input logic v, input logic rd, input logic wr,
                            input logic we_in, input logic sel, input logic [4:0] wa,
                            input logic [63:0] acc, input logic [63:0] sd,
                            input logic [63:0] rdat, input int k);
        logic memop;
        int   stalls;
        memop          = v & (rd | wr);
        in_valid       = v;
        mem_rd_in      = rd;
        mem_wr_in      = wr;
        WR_en_in       = we_in;
        mem_reg_sel_in = sel;
        WR_addr_in     = wa;
        accum_in       = acc;
        store_data_in  = sd;
        dmem_ack       = 1'($urandom_range(0, 1));
        dmem_rdata     = {$urandom, $urandom};
        @(negedge clk);
        chk("accum_pt", accum_out, acc);
        chk("waddr_pt", 64'(WR_addr_out), 64'(wa));
        chk("sel_pt", 64'(mem_reg_sel_out), 64'(sel));
        chk("mdata_hold", mem_data_out, model_rdata);
        if (!memop) begin
            chk("stall_nm", 64'(stall_out), 64'd0);
            chk("wren_nm", 64'(WR_en_out), 64'(v & we_in));
            chk("req_nm", 64'(dmem_req), 64'd0);
        end else begin
            stalls = 0;
            if (stall_out) stalls++;
            chk("wren_iss", 64'(WR_en_out), 64'd0);
            chk("req_iss", 64'(dmem_req), 64'd0);
            for (int c = 0; c <= k; c++) begin
                @(posedge clk); #1;
                dmem_ack   = (c == k);
                dmem_rdata = rdat;
                @(negedge clk);
                if (stall_out) stalls++;
                chk("req_hold", 64'(dmem_req), 64'd1);
                chk("we", 64'(dmem_we), 64'(wr));
                chk("addr", 64'(dmem_addr), 64'(acc[9:0]));
                chk("wdata", dmem_wdata, sd);
                chk("wren_req", 64'(WR_en_out), 64'd0);
            end
            @(posedge clk); #1;
            dmem_ack   = 1'($urandom_range(0, 1));
            dmem_rdata = {$urandom, $urandom};
            if (rd && !wr) model_rdata = rdat;
            @(negedge clk);
            chk("stall_cnt", 64'(stalls), 64'(k + 2));
            chk("stall_done", 64'(stall_out), 64'd0);
            chk("wren_done", 64'(WR_en_out), 64'(we_in));
            chk("req_done", 64'(dmem_req), 64'd0);
            chk("mdata_done", mem_data_out, model_rdata);
            chk("err_done", 64'(mem_err), 64'd0);
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
    endtask

    task automatic idle_inputs;
        in_valid = 1'b0; mem_rd_in = 1'b0; mem_wr_in = 1'b0; WR_en_in = 1'b0;
        mem_reg_sel_in = 1'b0; WR_addr_in = '0; accum_in = '0; store_data_in = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    initial begin
        int          kind;
        logic        v, rd, wr;
        n_chk = 0;
        n_pass = 0;
        model_rdata = '0;
        reset = 1'b0;
        idle_inputs();
        #12;
        chk("rst_req", 64'(dmem_req), 64'd0);
        chk("rst_we", 64'(dmem_we), 64'd0);
        chk("rst_addr", 64'(dmem_addr), 64'd0);
        chk("rst_wdata", dmem_wdata, 64'd0);
        chk("rst_mdata", mem_data_out, 64'd0);
        chk("rst_err", 64'(mem_err), 64'd0);
        chk("rst_stall", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Directed cases.
        do_instr(1, 0, 0, 1, 0, 5'd7, 64'h55, 64'h0, 64'h0, 0);
        do_instr(1, 1, 0, 1, 1, 5'd3, 64'h3C, 64'h0, 64'hDEADBEEF, 3);
        do_instr(1, 0, 1, 0, 0, 5'd0, 64'h10, 64'h1234, 64'h7777, 0);
        do_instr(1, 1, 1, 1, 0, 5'd4, 64'h20, 64'hAA, 64'h9999, 1);
        do_instr(1, 1, 0, 1, 1, 5'd9, 64'h21, 64'h0, 64'hCAFE0001, 2);

        // Reset asserted while a load is outstanding.
        in_valid = 1; mem_rd_in = 1; mem_wr_in = 0; WR_en_in = 1; accum_in = 64'h3FF;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_req", 64'(dmem_req), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_req", 64'(dmem_req), 64'd0);
        chk("arst_stall", 64'(stall_out), 64'd0);
        chk("arst_wren", 64'(WR_en_out), 64'd0);
        chk("arst_mdata", mem_data_out, 64'd0);
        idle_inputs();
        model_rdata = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        do_instr(1, 1, 0, 1, 1, 5'd2, 64'h11, 64'h0, 64'h0123456789ABCDEF, 1);

`ifdef MEM_TIMEOUT_EN
        begin
            int stalls;
            in_valid = 1; mem_rd_in = 1; mem_wr_in = 0; WR_en_in = 1; accum_in = 64'h44;
            dmem_ack = 0;
            stalls = 0;
            @(negedge clk);
            if (stall_out) stalls++;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (!stall_out) break;
                stalls++;
            end
            model_rdata = '1;
            chk("to_stalls", 64'(stalls), 64'd5);
            chk("to_err", 64'(mem_err), 64'd1);
            chk("to_wren", 64'(WR_en_out), 64'd0);
            chk("to_req", 64'(dmem_req), 64'd0);
            chk("to_mdata", mem_data_out, model_rdata);
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            chk("to_err_pulse", 64'(mem_err), 64'd0);
            @(posedge clk); #1;
        end
`endif

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            v  = (kind != 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rd = (kind == 1 || kind == 3) ? 1'b1 : 1'b0;
            wr = (kind == 2 || kind == 3) ? 1'b1 : 1'b0;
            if (kind == 0) begin
                rd = v ? 1'b0 : 1'($urandom_range(0, 1));
                wr = v ? 1'b0 : 1'($urandom_range(0, 1));
            end
            do_instr(v, rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, $urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage between the EX/MEM pipeline register and the MEM/WB register (pipe_mem_wb).
- Issues loads and stores to a variable-latency data memory over a req/ack handshake.
- Stalls upstream while an access is outstanding.
- Presents load data, ALU result and writeback control to the MEM/WB register, inserting a bubble (WR_en_out=0) on every stalled cycle.

Parameters:
- DATAPATH_WIDTH, 64, width of data, ALU result and memory words
- REGFILE_ADDR_WIDTH, 5, register-file address width
- MEM_ADDR_WIDTH, 10, data-memory word-address width
- TIMEOUT_CYCLES, 256, watchdog limit in cycles (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  EX/MEM holds a valid instruction
- accum_in  in  DATAPATH_WIDTH  ALU result; low MEM_ADDR_WIDTH bits are the memory word address
- store_data_in  in  DATAPATH_WIDTH  store data
- mem_rd_in  in  1  load
- mem_wr_in  in  1  store
- WR_addr_in  in  REGFILE_ADDR_WIDTH  destination register
- WR_en_in  in  1  register write enable
- mem_reg_sel_in  in  1  writeback mux select (1 = memory data)
- stall_out  out  1  hold EX/MEM and earlier stages
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  MEM_ADDR_WIDTH  word address, registered
- dmem_wdata  out  DATAPATH_WIDTH  write data, registered
- dmem_ack  in  1  one-cycle completion; dmem_rdata valid in the same cycle
- dmem_rdata  in  DATAPATH_WIDTH  read data
- mem_data_out  out  DATAPATH_WIDTH  captured load data, to MEM/WB
- accum_out  out  DATAPATH_WIDTH  pass-through of accum_in
- WR_addr_out  out  REGFILE_ADDR_WIDTH  pass-through of WR_addr_in
- WR_en_out  out  1  gated writeback enable
- mem_reg_sel_out  out  1  pass-through of mem_reg_sel_in
- mem_err  out  1  access-timeout pulse

Behaviour:
- Reset is asynchronous, active-low, single clock domain.
  - While reset=0: state=IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, rdata_q and the watchdog counter all 0; mem_err=0.
- memop = in_valid & (mem_rd_in | mem_wr_in). If both rd and wr are set, it is a store (wr priority); rdata_q is not updated.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Non-memop valid instruction: passes straight through in the same cycle. WR_en_out=WR_en_in; stall_out=0.
  - memop: stall_out=1, WR_en_out=0. At the clock edge, register dmem_req=1, dmem_we=mem_wr_in, dmem_addr=accum_in[MEM_ADDR_WIDTH-1:0], dmem_wdata=store_data_in; go to REQ.
  - in_valid=0: WR_en_out=0.
- REQ:
  - dmem_req and the other dmem_* outputs are held stable until dmem_ack.
  - stall_out=1, WR_en_out=0.
  - On dmem_ack: clear dmem_req at the edge, capture rdata_q<=dmem_rdata for loads, go to DONE.
- DONE (exactly one cycle):
  - stall_out=0, WR_en_out=WR_en_in; return to IDLE.
  - Upstream inputs are still stable in this cycle (they were held by the stall), so the MEM/WB register latches the completed instruction.
- mem_data_out=rdata_q at all times; it holds its last value for non-loads.
- accum_out, WR_addr_out, mem_reg_sel_out are combinational pass-throughs.
- Latency:
  - Non-memop: 0 added cycles.
  - memop with ack k cycles after dmem_req rises: k+2 cycles of stall_out (IDLE issue cycle, REQ cycles including the ack cycle), then 1 DONE cycle.
- Back-to-back memops: the second is seen in IDLE the cycle after DONE; no request overlap.
- dmem_ack outside REQ is ignored.
- Reset asserted mid-access: dmem_req drops immediately (asynchronous); the outstanding access is abandoned.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to REQ and increments each REQ cycle.
  - When it reaches TIMEOUT_CYCLES without dmem_ack: drop dmem_req, set rdata_q to all ones, go to DONE with WR_en_out forced 0.
  - mem_err=1 for that DONE cycle only.
- Undefined: no counter; REQ waits indefinitely; mem_err tied to 0.

Test Plan:
- Reset low mid-REQ with dmem_req=1 -> dmem_req=0, stall_out=0 and WR_en_out=0 immediately. After release, a fresh load is issued normally.
- Non-memop, in_valid=1, WR_en_in=1, WR_addr_in=7, accum_in=0x55 -> same cycle: WR_en_out=1, WR_addr_out=7, accum_out=0x55, stall_out=0, dmem_req stays 0.
- Load: accum_in=0x3C, ack 3 cycles after req with rdata=0xDEADBEEF -> dmem_addr=0x3C, stall_out high for 5 cycles, then one DONE cycle with mem_data_out=0xDEADBEEF, WR_en_out=1.
- Store: accum_in=0x10, store_data_in=0x1234, ack on the first REQ cycle -> dmem_we=1, dmem_wdata=0x1234, stall 2 cycles, mem_data_out unchanged.
- Both rd and wr set, then a back-to-back load -> first access has dmem_we=1 and rdata_q unchanged. The second request rises on the cycle after DONE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> req drops after 4 REQ cycles; DONE with mem_err=1, WR_en_out=0, mem_data_out=all ones.
